// File: rtl/armleocpu_decode_issue.sv
// -----------------------------------------------------------------------------
// armleocpu_decode_issue
//   Operand-fetch / issue stage sitting between fetch and execute. It accepts
//   one instruction per cycle and launches the synchronous register-file reads
//   (one-cycle latency). It then holds the instruction and its operands for
//   execute behind a valid/ready handshake. While the instruction waits, each
//   operand is kept coherent with writeback traffic through a per-operand
//   override register. This includes a write that lands in the accept cycle,
//   when the regfile still returns the pre-write value.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   f2d_valid/instr/pc/ready   fetch-side handshake
//   rs1_read/addr/rdata        regfile port 1 (rdata valid cycle after read)
//   rs2_read/addr/rdata        regfile port 2 (rdata valid cycle after read)
//   rd_write/addr/wdata        writeback write strobe snooped for hazards
//   d2e_valid/instr/pc         held instruction towards execute
//   d2e_rs1_data/rs2_data      operands towards execute
//   d2e_ready                  execute accepts
//   kill                       flush: drop the held instruction
// -----------------------------------------------------------------------------
module armleocpu_decode_issue #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f2d_valid,
  input  logic [31:0] f2d_instr,
  input  logic [31:0] f2d_pc,
  output logic        f2d_ready,
  output logic        rs1_read,
  output logic [4:0]  rs1_addr,
  input  logic [31:0] rs1_rdata,
  output logic        rs2_read,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs2_rdata,
  input  logic        rd_write,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_wdata,
  output logic        d2e_valid,
  output logic [31:0] d2e_instr,
  output logic [31:0] d2e_pc,
  output logic [31:0] d2e_rs1_data,
  output logic [31:0] d2e_rs2_data,
  input  logic        d2e_ready,
  input  logic        kill
);

  logic        r_vld_p1;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_p1;
  logic [4:0]  r_rs1_addr_p1;
  logic [4:0]  r_rs2_addr_p1;
  logic        r_ov1_vld_p1;
  logic        r_ov2_vld_p1;
  logic [31:0] r_ov1_data_p1;
  logic [31:0] r_ov2_data_p1;

  logic w_accept;
  logic w_advance;
  logic w_wb_live;
  logic w_in_hit1;
  logic w_in_hit2;
  logic w_held_hit1;
  logic w_held_hit2;

  // ---- p0: fetch-side handshake and regfile read launch ----
  // f2d_ready deliberately ignores f2d_valid to avoid a combinational loop
  // through fetch.
  assign f2d_ready = !kill && (!r_vld_p1 || d2e_ready);
  assign w_accept  = f2d_valid && f2d_ready;
  assign w_advance = r_vld_p1 && d2e_ready;

  assign rs1_read  = w_accept;
  assign rs2_read  = w_accept;
  assign rs1_addr  = f2d_instr[19:15];
  assign rs2_addr  = f2d_instr[24:20];

  // x0 writes never override: the regfile keeps storage[0] at zero.
  assign w_wb_live   = (BYPASS_EN != 0) && rd_write && (rd_addr != 5'd0);
  assign w_in_hit1   = w_wb_live && (rd_addr == f2d_instr[19:15]);
  assign w_in_hit2   = w_wb_live && (rd_addr == f2d_instr[24:20]);
  assign w_held_hit1 = w_wb_live && (rd_addr == r_rs1_addr_p1);
  assign w_held_hit2 = w_wb_live && (rd_addr == r_rs2_addr_p1);

  // ---- p0 -> p1: capture instruction, track writeback while held ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_instr_p1    <= '0;
      r_pc_p1       <= '0;
      r_rs1_addr_p1 <= '0;
      r_rs2_addr_p1 <= '0;
      r_ov1_vld_p1  <= 1'b0;
      r_ov2_vld_p1  <= 1'b0;
      r_ov1_data_p1 <= '0;
      r_ov2_data_p1 <= '0;
    end else if (kill) begin
      r_vld_p1     <= 1'b0;
      r_ov1_vld_p1 <= 1'b0;
      r_ov2_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      // A replacing accept only looks at the incoming addresses.
      r_vld_p1      <= 1'b1;
      r_instr_p1    <= f2d_instr;
      r_pc_p1       <= f2d_pc;
      r_rs1_addr_p1 <= f2d_instr[19:15];
      r_rs2_addr_p1 <= f2d_instr[24:20];
      r_ov1_vld_p1  <= w_in_hit1;
      r_ov2_vld_p1  <= w_in_hit2;
      if (w_in_hit1) r_ov1_data_p1 <= rd_wdata;
      if (w_in_hit2) r_ov2_data_p1 <= rd_wdata;
    end else if (w_advance) begin
      r_vld_p1     <= 1'b0;
      r_ov1_vld_p1 <= 1'b0;
      r_ov2_vld_p1 <= 1'b0;
    end else if (r_vld_p1) begin
      // Stalled: the regfile output is frozen, so every later write to a
      // held source is captured here; the newest write wins.
      if (w_held_hit1) begin
        r_ov1_vld_p1  <= 1'b1;
        r_ov1_data_p1 <= rd_wdata;
      end
      if (w_held_hit2) begin
        r_ov2_vld_p1  <= 1'b1;
        r_ov2_data_p1 <= rd_wdata;
      end
    end
  end

  // ---- p1: operand select towards execute ----
  assign d2e_valid    = r_vld_p1;
  assign d2e_instr    = r_instr_p1;
  assign d2e_pc       = r_pc_p1;
  assign d2e_rs1_data = r_ov1_vld_p1 ? r_ov1_data_p1 : rs1_rdata;
  assign d2e_rs2_data = r_ov2_vld_p1 ? r_ov2_data_p1 : rs2_rdata;

endmodule

// File: doc/armleocpu_decode_issue.md
Name: armleocpu_decode_issue

Overview:
- Operand-fetch/issue stage between fetch and execute.
- Accepts one instruction per cycle from fetch and launches the synchronous register file reads (rs1/rs2, 1-cycle read latency).
- Presents the instruction plus operands to execute over a valid/ready handshake.
- Keeps operands coherent against writeback traffic while the instruction waits, including writes that land in the same cycle as the read.

Parameters:
- BYPASS_EN, 1: 1 = apply writeback bypass/override; 0 = operands come only from regfile read data (for debug/area).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f2d_valid  in  1  fetch presents instruction.
- f2d_instr  in  32  instruction word.
- f2d_pc  in  32  instruction PC.
- f2d_ready  out  1  stage accepts this cycle.
- rs1_read  out  1  regfile rs1 read enable.
- rs1_addr  out  5  f2d_instr[19:15].
- rs1_rdata  in  32  regfile rs1 data, valid the cycle after rs1_read.
- rs2_read  out  1  regfile rs2 read enable.
- rs2_addr  out  5  f2d_instr[24:20].
- rs2_rdata  in  32  regfile rs2 data, valid the cycle after rs2_read.
- rd_write  in  1  writeback write strobe (same net as regfile).
- rd_addr  in  5  writeback destination.
- rd_wdata  in  32  writeback data.
- d2e_valid  out  1  instruction/operands valid to execute.
- d2e_instr  out  32  held instruction.
- d2e_pc  out  32  held PC.
- d2e_rs1_data  out  32  rs1 operand.
- d2e_rs2_data  out  32  rs2 operand.
- d2e_ready  in  1  execute accepts.
- kill  in  1  flush (branch/trap): drop held instruction.

Behaviour:
- Reset: asynchronous, active-low. Registers: d2e_valid=0, d2e_instr=0, d2e_pc=0, held rs1/rs2 addr=0, ov1_valid=ov2_valid=0, ov1_data=ov2_data=0.
- Two states, encoded by d2e_valid:
  - EMPTY (d2e_valid=0).
  - FULL (d2e_valid=1).
- f2d_ready = !kill && (!d2e_valid || d2e_ready). Combinational; the fetch-side handshake must not depend on f2d_valid.
- accept = f2d_valid && f2d_ready.
  - rs1_read = rs2_read = accept.
  - rs1_addr/rs2_addr are driven combinationally from f2d_instr fields every cycle.
- On accept at cycle N:
  - Capture instr, pc and the rs1/rs2 addrs.
  - d2e_valid=1 at N+1; operands are valid at N+1.
  - Throughput is 1 instruction/cycle when d2e_ready stays high.
- Advance without accept (FULL, d2e_ready=1, no f2d_valid): go to EMPTY, clear ov*_valid.
- Stall (FULL, d2e_ready=0):
  - Hold all d2e_* stable.
  - rs*_read stays 0, so regfile rdata holds.
- Bypass/override (BYPASS_EN=1), per operand k:
  - Accept cycle: if rd_write && rd_addr!=0 && rd_addr==incoming rsk addr, set ovk_valid=1 and ovk_data=rd_wdata. Otherwise ovk_valid=0. (The regfile returns the pre-write value in this case.)
  - FULL and not advancing: if rd_write && rd_addr!=0 && rd_addr==held rsk addr, set ovk_valid=1 and ovk_data=rd_wdata. The newest write wins.
  - d2e_rsk_data = ovk_valid ? ovk_data : rsk_rdata.
- x0:
  - rd_addr==0 never triggers override.
  - rs addr 0 relies on regfile storage[0]=0.
- kill:
  - Highest priority.
  - Next cycle d2e_valid=0 and ov*_valid=0.
  - No accept that cycle; f2d_ready=0 and rs*_read=0.
  - kill while EMPTY has no effect beyond blocking accept.
- Simultaneous advance and accept: the new instruction replaces the old. Override evaluation uses the incoming addresses only.
- Reset mid-stall: instruction dropped, d2e_valid=0 immediately (asynchronous).
- d2e_instr/d2e_pc are don't-care when d2e_valid=0 but retain their last value (no X).

Test Plan:
- Write x5=0x1234_5678 via rd_write earlier; accept addi with rs1=5 at N -> rs1_read=1, rs1_addr=5 at N; d2e_valid=1, d2e_rs1_data=0x12345678 at N+1.
- Same-cycle hazard: accept rs1=7 at N while rd_write x7=0xDEAD_BEEF -> d2e_rs1_data=0xDEADBEEF at N+1 (regfile returned old 0).
- Stall with write: FULL with rs2=9, d2e_ready=0 for 3 cycles; writes x9=0x1, then x9=0x2 -> d2e_rs2_data=0x2 and d2e_instr unchanged; release -> EMPTY next cycle.
- Back-to-back: 4 instructions with f2d_valid and d2e_ready held 1 -> 4 consecutive d2e_valid cycles, PCs 0x0,0x4,0x8,0xC in order, no bubbles.
- kill while FULL and f2d_valid=1 -> f2d_ready=0 and rs1_read=0 that cycle; d2e_valid=0 next cycle; the following cycle accepts normally.
- x0 guard: rd_write rd_addr=0 wdata=0xFFFF_FFFF while accepting rs1=0 -> d2e_rs1_data=0. Also assert rst_n low mid-stall -> d2e_valid=0 without a clock edge.
